// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: decodes CPU memory-port requests onto NUM_SLOTS peripheral
// slots, waits for the selected slot's ready handshake while stalling the CPU,
// and reports timeouts and unmapped or malformed accesses as bus errors. Bus
// errors are counted in a saturating 8-bit counter.
module mmio_bus_fabric #(
   parameter int NUM_SLOTS = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int SEL_W = 4,
   parameter int TIMEOUT = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 16'hFFFF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_read,
   input  logic                        cpu_write,
   input  logic [ADDR_W-1:0]           cpu_addr,
   input  logic [DATA_W-1:0]           cpu_wdata,
   output logic [DATA_W-1:0]           cpu_rdata,
   output logic                        cpu_stall,
   output logic                        bus_err,
   output logic [7:0]                  err_count,
   output logic [NUM_SLOTS-1:0]        slot_cs,
   output logic                        slot_read,
   output logic                        slot_write,
   output logic [ADDR_W-SEL_W-1:0]     slot_addr,
   output logic [DATA_W-1:0]           slot_wdata,
   input  logic [NUM_SLOTS*DATA_W-1:0] slot_rdata,
   input  logic [NUM_SLOTS-1:0]        slot_ready
);

   localparam int OFF_W = ADDR_W - SEL_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t               state_r;
   logic [DATA_W-1:0]    cpu_rdata_r;
   logic                 bus_err_r;
   logic [7:0]           err_count_r;
   logic [NUM_SLOTS-1:0] slot_cs_r;
   logic                 slot_read_r;
   logic                 slot_write_r;
   logic [OFF_W-1:0]     slot_addr_r;
   logic [DATA_W-1:0]    slot_wdata_r;
   logic [CNT_W-1:0]     wait_cnt_r;

   logic [SEL_W-1:0]     idx_s;
   logic                 req_s;
   logic                 req_err_s;
   logic [NUM_SLOTS-1:0] cs_dec_s;
   logic                 sel_ready_s;
   logic [DATA_W-1:0]    sel_rdata_s;

   // Error counter holds at its maximum instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Decode the incoming request and pick the response of the selected slot.
   always_comb begin
      idx_s       = cpu_addr[ADDR_W-1 -: SEL_W];
      req_s       = cpu_read | cpu_write;
      req_err_s   = (32'(idx_s) >= 32'(NUM_SLOTS)) | (cpu_read & cpu_write);
      cs_dec_s    = '0;
      sel_ready_s = 1'b0;
      sel_rdata_s = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cs_dec_s[i] = (32'(idx_s) == 32'(i));
         // slot_cs_r is one-hot, so ready/data from other slots are masked off.
         sel_ready_s = sel_ready_s | (slot_ready[i] & slot_cs_r[i]);
         sel_rdata_s = sel_rdata_s
                     | (slot_rdata[i*DATA_W +: DATA_W] & {DATA_W{slot_cs_r[i]}});
      end
   end

   // Stall follows the request in IDLE, is forced in ACCESS and drops in DONE.
   always_comb begin
      case (state_r)
         IDLE:    cpu_stall = ~rst & req_s;
         ACCESS:  cpu_stall = ~rst;
         default: cpu_stall = 1'b0;
      endcase
   end

   // Access sequencer: latch and decode, wait for ready or timeout, one DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cpu_rdata_r  <= '0;
         bus_err_r    <= 1'b0;
         err_count_r  <= 8'd0;
         slot_cs_r    <= '0;
         slot_read_r  <= 1'b0;
         slot_write_r <= 1'b0;
         slot_addr_r  <= '0;
         slot_wdata_r <= '0;
         wait_cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               bus_err_r <= 1'b0;
               if (req_s) begin
                  slot_addr_r  <= cpu_addr[OFF_W-1:0];
                  slot_wdata_r <= cpu_wdata;
                  if (req_err_s) begin
                     // Unmapped or read+write together: no slot is touched.
                     if (cpu_read) begin
                        cpu_rdata_r <= ERR_DATA;
                     end
                     bus_err_r   <= 1'b1;
                     err_count_r <= sat_inc(err_count_r);
                     state_r     <= DONE;
                  end else begin
                     slot_cs_r    <= cs_dec_s;
                     slot_read_r  <= cpu_read;
                     slot_write_r <= cpu_write;
                     wait_cnt_r   <= CNT_W'(1);
                     state_r      <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (sel_ready_s) begin
                  // Ready on the final allowed cycle still counts as success.
                  if (slot_read_r) begin
                     cpu_rdata_r <= sel_rdata_s;
                  end
                  slot_cs_r    <= '0;
                  slot_read_r  <= 1'b0;
                  slot_write_r <= 1'b0;
                  wait_cnt_r   <= '0;
                  state_r      <= DONE;
               end else if (wait_cnt_r == TIMEOUT_C) begin
                  if (slot_read_r) begin
                     cpu_rdata_r <= ERR_DATA;
                  end
                  bus_err_r    <= 1'b1;
                  err_count_r  <= sat_inc(err_count_r);
                  slot_cs_r    <= '0;
                  slot_read_r  <= 1'b0;
                  slot_write_r <= 1'b0;
                  wait_cnt_r   <= '0;
                  state_r      <= DONE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               // Request still held here is ignored; CPU drops it now.
               bus_err_r <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               bus_err_r    <= 1'b0;
               slot_cs_r    <= '0;
               slot_read_r  <= 1'b0;
               slot_write_r <= 1'b0;
               wait_cnt_r   <= '0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata  = cpu_rdata_r;
   assign bus_err    = bus_err_r;
   assign err_count  = err_count_r;
   assign slot_cs    = slot_cs_r;
   assign slot_read  = slot_read_r;
   assign slot_write = slot_write_r;
   assign slot_addr  = slot_addr_r;
   assign slot_wdata = slot_wdata_r;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric with default parameters
// (8 slots, 16-bit address/data, 4-bit select, TIMEOUT 15).
module tb_mmio_bus_fabric;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_read;
   logic         cpu_write;
   logic [15:0]  cpu_addr;
   logic [15:0]  cpu_wdata;
   logic [15:0]  cpu_rdata;
   logic         cpu_stall;
   logic         bus_err;
   logic [7:0]   err_count;
   logic [7:0]   slot_cs;
   logic         slot_read;
   logic         slot_write;
   logic [11:0]  slot_addr;
   logic [15:0]  slot_wdata;
   logic [127:0] slot_rdata;
   logic [7:0]   slot_ready;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Snapshot of the first ACCESS cycle and per-access statistics.
   int          stall_n;
   int          wr_cycles;
   logic [7:0]  cs_first;
   logic [11:0] addr_first;
   logic        rd_first;
   logic [15:0] wdata_first;

   mmio_bus_fabric dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .bus_err    (bus_err),
      .err_count  (err_count),
      .slot_cs    (slot_cs),
      .slot_read  (slot_read),
      .slot_write (slot_write),
      .slot_addr  (slot_addr),
      .slot_wdata (slot_wdata),
      .slot_rdata (slot_rdata),
      .slot_ready (slot_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue a request and run until stall drops (DUT left in DONE, request held).
   // ready_at = ACCESS cycle (1-based) in which the slot signals ready; 0 = never.
   task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int ready_at,
                            input int slot, input logic [15:0] rdat);
      cpu_read  = rd;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      slot_rdata[slot*16 +: 16] = rdat;
      #1;
      stall_n     = 0;
      wr_cycles   = 0;
      cs_first    = 8'h00;
      addr_first  = 12'h000;
      rd_first    = 1'b0;
      wdata_first = 16'h0000;
      while (cpu_stall === 1'b1 && stall_n < 40) begin
         stall_n++;
         if (stall_n == 2) begin
            cs_first    = slot_cs;
            addr_first  = slot_addr;
            rd_first    = slot_read;
            wdata_first = slot_wdata;
         end
         if (slot_write === 1'b1) wr_cycles++;
         if (ready_at != 0 && stall_n - 1 == ready_at) slot_ready[slot] = 1'b1;
         tick;
      end
   endtask

   task automatic release_bus;
      cpu_read   = 1'b0;
      cpu_write  = 1'b0;
      slot_ready = 8'h00;
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      cpu_read   = 1'b0;
      cpu_write  = 1'b0;
      cpu_addr   = 16'h0000;
      cpu_wdata  = 16'h0000;
      slot_rdata = '0;
      slot_ready = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_stall", cpu_stall, 32'h0);
      check("rst_err", bus_err, 32'h0);
      check("rst_cnt", err_count, 32'h0);
      check("rst_cs", slot_cs, 32'h0);
      check("rst_strobes", {slot_read, slot_write}, 32'h0);
      check("rst_addr", slot_addr, 32'h0);
      check("rst_wdata", slot_wdata, 32'h0);
      rst = 1'b0;
      tick;

      // 1: read slot 2, ready in first ACCESS cycle
      do_access(1'b1, 1'b0, 16'h2034, 16'h0000, 1, 2, 16'hBEEF);
      check("t1_stall", stall_n, 32'd2);
      check("t1_cs", cs_first, 32'h04);
      check("t1_addr", addr_first, 32'h034);
      check("t1_rd", rd_first, 32'h1);
      check("t1_rdata", cpu_rdata, 32'hBEEF);
      check("t1_err", bus_err, 32'h0);
      check("t1_done_cs", slot_cs, 32'h0);
      release_bus;
      check("t1_idle_err", bus_err, 32'h0);

      // 2: write slot 5, ready in third ACCESS cycle
      do_access(1'b0, 1'b1, 16'h5001, 16'h1234, 3, 5, 16'h0000);
      check("t2_stall", stall_n, 32'd4);
      check("t2_cs", cs_first, 32'h20);
      check("t2_addr", addr_first, 32'h001);
      check("t2_wdata", wdata_first, 32'h1234);
      check("t2_wr_cycles", wr_cycles, 32'd3);
      check("t2_rdata_kept", cpu_rdata, 32'hBEEF);
      check("t2_err", bus_err, 32'h0);
      release_bus;

      // 3: timeout on slot 1, then ready exactly on cycle 15
      do_access(1'b1, 1'b0, 16'h1000, 16'h0000, 0, 1, 16'h7777);
      check("t3_stall", stall_n, 32'd16);
      check("t3_rdata", cpu_rdata, 32'hFFFF);
      check("t3_err", bus_err, 32'h1);
      check("t3_cnt", err_count, 32'd1);
      release_bus;
      check("t3_err_pulse", bus_err, 32'h0);
      do_access(1'b1, 1'b0, 16'h1002, 16'h0000, 15, 1, 16'h5A5A);
      check("t3b_stall", stall_n, 32'd16);
      check("t3b_rdata", cpu_rdata, 32'h5A5A);
      check("t3b_err", bus_err, 32'h0);
      check("t3b_cnt", err_count, 32'd1);
      release_bus;

      // 4: unmapped address, then read+write together
      do_access(1'b1, 1'b0, 16'hA000, 16'h0000, 0, 0, 16'h0000);
      check("t4_stall", stall_n, 32'd1);
      check("t4_cs", slot_cs, 32'h0);
      check("t4_rdata", cpu_rdata, 32'hFFFF);
      check("t4_err", bus_err, 32'h1);
      check("t4_cnt", err_count, 32'd2);
      release_bus;
      do_access(1'b1, 1'b0, 16'h3000, 16'h0000, 1, 3, 16'h1111);
      check("t4_good_rdata", cpu_rdata, 32'h1111);
      release_bus;
      do_access(1'b1, 1'b1, 16'h3000, 16'hAAAA, 0, 3, 16'h1111);
      check("t4rw_stall", stall_n, 32'd1);
      check("t4rw_cs", slot_cs, 32'h0);
      check("t4rw_rdata", cpu_rdata, 32'hFFFF);
      check("t4rw_err", bus_err, 32'h1);
      check("t4rw_cnt", err_count, 32'd3);
      release_bus;

      // 5: reset in the middle of an access to slot 3
      cpu_read = 1'b1;
      cpu_addr = 16'h3010;
      #1;
      tick;
      tick;
      check("t5_cs_before", slot_cs, 32'h08);
      check("t5_stall_before", cpu_stall, 32'h1);
      rst      = 1'b1;
      cpu_read = 1'b0;
      #1;
      check("t5_cs", slot_cs, 32'h0);
      check("t5_stall", cpu_stall, 32'h0);
      check("t5_rdata", cpu_rdata, 32'h0);
      check("t5_cnt", err_count, 32'h0);
      check("t5_rd", slot_read, 32'h0);
      tick;
      rst = 1'b0;
      tick;
      do_access(1'b1, 1'b0, 16'h3020, 16'h0000, 1, 3, 16'h3333);
      check("t5_new_stall", stall_n, 32'd2);
      check("t5_new_rdata", cpu_rdata, 32'h3333);
      check("t5_new_err", bus_err, 32'h0);
      release_bus;

      // 6: 260 unmapped accesses saturate the error counter
      for (int i = 0; i < 260; i++) begin
         do_access(1'b1, 1'b0, 16'hF000, 16'h0000, 0, 0, 16'h0000);
         release_bus;
         if (i == 253) check("t6_cnt_254", err_count, 32'd254);
         if (i == 254) check("t6_cnt_255", err_count, 32'd255);
      end
      check("t6_cnt_sat", err_count, 32'd255);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
